uart_fp32_operand_rx: RTL and testbench
=======================================

Name: uart_fp32_operand_rx

Overview:
UART receiver and operand assembler that sits on the input side of the FP32 adder datapath. It deserialises 8N1 bytes from the serial line and packs eight consecutive bytes into two FP32 operands, alpha and bravo. It presents the pair through a valid/ready handshake to the adder stage. Results return to the host through the existing UART transmit path.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200 baud); minimum 4.
GAP_TIMEOUT_BITS, 32, idle bit-periods after which a partially assembled operand pair is discarded.

Ports:
clk  input  1  system clock; single clock domain.
rst  input  1  synchronous, active-high reset.
rx_serial  input  1  asynchronous UART line; idles high.
out_ready  input  1  downstream accepts the operand pair.
out_valid  output  1  alpha/bravo hold a complete pair.
alpha  output  32  operand A, IEEE-754 single.
bravo  output  32  operand B, IEEE-754 single.
frame_error  output  1  one-cycle pulse when a bad stop bit is detected.
overrun  output  1  one-cycle pulse when a completed pair is dropped.
gap_timeout  output  1  one-cycle pulse when a partial pair is discarded.

Behaviour:
- Reset. On rst high at a clk edge:
  - out_valid, frame_error, overrun and gap_timeout go to 0.
  - alpha and bravo go to 0.
  - FSM goes to IDLE; byte index, bit counter and baud counter go to 0.
  - Synchronizer flops go to 1.
  - A reset asserted mid-byte or mid-pair discards all partial data. No pulse is generated.
- Input synchronisation. rx_serial passes through a 2-flop synchronizer. All decisions use the synchronised signal (rx_s).
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: wait for rx_s == 0, then go to START and clear the baud counter.
  - START: at count CLKS_PER_BIT/2 (integer division), sample rx_s.
    - If 0: a valid start bit. Go to DATA and clear counters.
    - If 1: a glitch. Return to IDLE with no flag.
  - DATA: sample every CLKS_PER_BIT cycles, measured from the start-bit midpoint. Receive 8 bits, LSB first. After bit 7, go to STOP.
  - STOP: sample after CLKS_PER_BIT cycles.
    - If rx_s == 1: the byte is accepted.
    - If rx_s == 0: pulse frame_error, discard the byte, reset the byte index to 0, return to IDLE, and require rx_s == 1 before a new start is recognised.
    - In both cases, return to IDLE.
- Byte assembly.
  - Accepted bytes shift into a 64-bit staging register, MSB-first within each operand.
  - Bytes 0..3 form alpha[31:24], [23:16], [15:8], [7:0].
  - Bytes 4..7 form bravo[31:24] .. [7:0].
  - The byte index runs 0..7 and wraps to 0 after byte 7.
- Output load. In the cycle after the 8th stop bit is accepted:
  - The staging register loads alpha/bravo and out_valid = 1, but only if out_valid == 0 or (out_valid && out_ready) in that cycle.
  - Otherwise, pulse overrun; the new pair is dropped and the held pair is unchanged.
- Handshake.
  - alpha, bravo and out_valid stay stable while out_valid && !out_ready.
  - A transfer occurs on a clk edge where out_valid && out_ready. out_valid clears on that edge unless a new pair loads on the same edge, in which case out_valid stays 1 with the new data.
  - out_ready never affects reception; serial reception continues while a pair is held.
- Gap timeout.
  - While in IDLE with byte index != 0, an idle counter runs.
  - When it reaches GAP_TIMEOUT_BITS*CLKS_PER_BIT, the byte index goes to 0 and gap_timeout pulses for 1 cycle.
  - The counter clears on any start detection and whenever the byte index is 0.
- Latency. From the stop-bit sample of byte 7 to out_valid high is 1 clk, plus the 2-cycle synchronizer delay relative to the line.
- Widths.
  - Baud counter: $clog2(CLKS_PER_BIT)+1 bits.
  - Idle counter: sized for GAP_TIMEOUT_BITS*CLKS_PER_BIT.
  - All counter compares are unsigned.

Test Plan:
- Basic pair: bench uses CLKS_PER_BIT=16 and out_ready=1. Send bytes 3F 80 00 00 40 00 00 00 -> alpha=0x3F800000 and bravo=0x40000000 with a single out_valid pulse. frame_error, overrun and gap_timeout stay 0.
- Backpressure: hold out_ready=0 and send pair C0490FDB / 3F800000 -> out_valid stays 1 with stable data. Raise out_ready -> out_valid falls after 1 cycle. A second pair sent while held -> overrun pulses once and alpha remains 0xC0490FDB.
- Frame error: drive stop bit 0 on byte 2 -> frame_error pulses once. Then send a full clean 8 bytes 00 00 80 3F 00 00 00 40 -> alpha=0x0000803F, bravo=0x00000040.
- Glitch rejection: a low pulse of CLKS_PER_BIT/4 cycles on an idle line -> no byte accepted and the byte index stays 0. A subsequent pair decodes correctly.
- Gap timeout: send 3 bytes, idle 32 bit-periods -> gap_timeout pulses once. Then send 8 bytes 7F 80 00 00 FF 80 00 00 -> alpha=0x7F800000, bravo=0xFF800000.
- Reset mid-pair: assert rst for 1 cycle after byte 5 -> all outputs are 0. The next 8 bytes form a fresh pair with no stale bytes.

Source files
------------

// File: rtl/uart_fp32_operand_rx.sv
// 8N1 UART receiver that packs eight bytes into two big-endian FP32 operands
// (alpha, bravo) and offers them downstream through a valid/ready handshake.
module uart_fp32_operand_rx #(
  parameter int CLKS_PER_BIT     = 868,
  parameter int GAP_TIMEOUT_BITS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_serial,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] alpha,
  output logic [31:0] bravo,
  output logic        frame_error,
  output logic        overrun,
  output logic        gap_timeout
);

  localparam int BAUD_W    = $clog2(CLKS_PER_BIT) + 1;
  localparam int GAP_LIMIT = GAP_TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int IDLE_W    = $clog2(GAP_LIMIT + 1);

  localparam logic [BAUD_W-1:0] BAUD_ZERO = BAUD_W'(0);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  localparam logic [BAUD_W-1:0] HALF_CNT  = BAUD_W'(CLKS_PER_BIT / 2);
  localparam logic [BAUD_W-1:0] FULL_CNT  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [IDLE_W-1:0] IDLE_ZERO = IDLE_W'(0);
  localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);
  localparam logic [IDLE_W-1:0] GAP_CNT   = IDLE_W'(GAP_LIMIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t              state_r, state_s;
  logic                rx_meta_r, rx_sync_r;
  logic [BAUD_W-1:0]   baud_r, baud_s;
  logic [2:0]          bit_r, bit_s;
  logic [7:0]          data_r, data_s;
  logic [2:0]          byte_idx_r;
  logic [63:0]         stage_r;
  logic [IDLE_W-1:0]   idle_cnt_r, idle_s;
  logic                wait_high_r;
  logic                pair_done_r;
  logic                start_s, accept_s, ferr_s, gap_fire_s;
  logic                out_valid_r, frame_error_r, overrun_r, gap_timeout_r;
  logic [31:0]         alpha_r, bravo_r;

  // Receive FSM next-state, bit sampling and gap-timer decisions.
  always_comb begin
    state_s    = state_r;
    baud_s     = baud_r + BAUD_ONE;
    bit_s      = bit_r;
    data_s     = data_r;
    start_s    = 1'b0;
    accept_s   = 1'b0;
    ferr_s     = 1'b0;
    gap_fire_s = 1'b0;
    idle_s     = idle_cnt_r;
    case (state_r)
      IDLE: begin
        baud_s = BAUD_ZERO;
        // After a framing error the line must go high before a new start counts.
        if (!rx_sync_r && !wait_high_r) begin
          state_s = START;
          start_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (baud_r == HALF_CNT) begin
          baud_s  = BAUD_ZERO;
          bit_s   = 3'd0;
          state_s = rx_sync_r ? IDLE : DATA;
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        if (baud_r == FULL_CNT) begin
          baud_s  = BAUD_ZERO;
          data_s  = {rx_sync_r, data_r[7:1]};
          bit_s   = bit_r + 3'd1;
          state_s = (bit_r == 3'd7) ? STOP : DATA;
        end else begin
          state_s = DATA;
        end
      end
      STOP: begin
        if (baud_r == FULL_CNT) begin
          baud_s   = BAUD_ZERO;
          state_s  = IDLE;
          accept_s = rx_sync_r;
          ferr_s   = !rx_sync_r;
        end else begin
          state_s = STOP;
        end
      end
      default: begin
        state_s = IDLE;
        baud_s  = BAUD_ZERO;
      end
    endcase

    if ((byte_idx_r == 3'd0) || start_s) begin
      idle_s = IDLE_ZERO;
    end else if (state_r == IDLE) begin
      if (idle_cnt_r == GAP_CNT) begin
        gap_fire_s = 1'b1;
        idle_s     = IDLE_ZERO;
      end else begin
        idle_s = idle_cnt_r + IDLE_ONE;
      end
    end else begin
      idle_s = idle_cnt_r;
    end
  end

  // Synchronizer, FSM state, counters and byte assembly.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_r   <= 1'b1;
      rx_sync_r   <= 1'b1;
      state_r     <= IDLE;
      baud_r      <= BAUD_ZERO;
      bit_r       <= 3'd0;
      data_r      <= 8'h00;
      byte_idx_r  <= 3'd0;
      stage_r     <= 64'h0;
      idle_cnt_r  <= IDLE_ZERO;
      wait_high_r <= 1'b0;
      pair_done_r <= 1'b0;
    end else begin
      rx_meta_r  <= rx_serial;
      rx_sync_r  <= rx_meta_r;
      state_r    <= state_s;
      baud_r     <= baud_s;
      bit_r      <= bit_s;
      data_r     <= data_s;
      idle_cnt_r <= idle_s;
      if (ferr_s) begin
        wait_high_r <= 1'b1;
      end else if (rx_sync_r) begin
        wait_high_r <= 1'b0;
      end
      if (ferr_s || gap_fire_s) begin
        byte_idx_r <= 3'd0;
      end else if (accept_s) begin
        byte_idx_r <= byte_idx_r + 3'd1;
      end
      if (accept_s) begin
        stage_r <= {stage_r[55:0], data_r};
      end
      pair_done_r <= accept_s && (byte_idx_r == 3'd7);
    end
  end

  // Output pair register, handshake and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r   <= 1'b0;
      alpha_r       <= 32'h0;
      bravo_r       <= 32'h0;
      frame_error_r <= 1'b0;
      overrun_r     <= 1'b0;
      gap_timeout_r <= 1'b0;
    end else begin
      frame_error_r <= ferr_s;
      gap_timeout_r <= gap_fire_s;
      overrun_r     <= pair_done_r && out_valid_r && !out_ready;
      if (pair_done_r && (!out_valid_r || out_ready)) begin
        alpha_r     <= stage_r[63:32];
        bravo_r     <= stage_r[31:0];
        out_valid_r <= 1'b1;
      end else if (out_valid_r && out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign out_valid   = out_valid_r;
  assign alpha       = alpha_r;
  assign bravo       = bravo_r;
  assign frame_error = frame_error_r;
  assign overrun     = overrun_r;
  assign gap_timeout = gap_timeout_r;

endmodule

// File: tb/tb_uart_fp32_operand_rx.sv
// Scoreboard bench for uart_fp32_operand_rx: directed serial pairs, monitor
// pops expected operand pairs on each transfer and counts status pulses.
module tb_uart_fp32_operand_rx;

  localparam int CPB = 16;
  localparam int GAP = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_serial = 1'b1;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] alpha, bravo;
  logic        frame_error, overrun, gap_timeout;

  int checks = 0;
  int failures = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int gt_cnt = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;

  uart_fp32_operand_rx #(.CLKS_PER_BIT(CPB), .GAP_TIMEOUT_BITS(GAP)) dut (
    .clk(clk), .rst(rst), .rx_serial(rx_serial), .out_ready(out_ready),
    .out_valid(out_valid), .alpha(alpha), .bravo(bravo),
    .frame_error(frame_error), .overrun(overrun), .gap_timeout(gap_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare every transfer against the scoreboard and count pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_error === 1'b1) fe_cnt++;
      if (overrun === 1'b1) ov_cnt++;
      if (gap_timeout === 1'b1) gt_cnt++;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pair: got %h%h expected none", alpha, bravo);
        end else begin
          mon_e = exp_q.pop_front();
          chk("pair", {alpha, bravo}, mon_e);
        end
      end
    end
  end

  task automatic drive_bit(input logic v);
    rx_serial = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx_serial = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
    rx_serial = 1'b1;
  endtask

  task automatic send_pair(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] w;
    w = {a, b};
    for (int i = 7; i >= 0; i--) send_byte(w[i*8 +: 8], 1'b1);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int fe0, ov0, gt0;
    logic stable;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", 64'(out_valid), 64'd0);
    chk("reset_alpha", 64'(alpha), 64'd0);
    chk("reset_bravo", 64'(bravo), 64'd0);
    chk("reset_flags", {61'd0, frame_error, overrun, gap_timeout}, 64'd0);
    rst = 1'b0;
    idle(10);

    // Basic pair with out_ready held high.
    out_ready = 1'b1;
    exp_q.push_back({32'h3F800000, 32'h40000000});
    send_pair(32'h3F800000, 32'h40000000);
    wait_drain("basic_drain");
    idle(4);
    chk("basic_valid_low", 64'(out_valid), 64'd0);
    chk("basic_flags", 64'(fe_cnt + ov_cnt + gt_cnt), 64'd0);

    // Backpressure, stability and overrun.
    out_ready = 1'b0;
    ov0 = ov_cnt;
    exp_q.push_back({32'hC0490FDB, 32'h3F800000});
    send_pair(32'hC0490FDB, 32'h3F800000);
    chk("bp_valid_held", 64'(out_valid), 64'd1);
    stable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || alpha !== 32'hC0490FDB || bravo !== 32'h3F800000) stable = 1'b0;
    end
    #1;
    chk("bp_stable", 64'(stable), 64'd1);
    send_pair(32'h11223344, 32'h55667788);
    idle(4);
    chk("bp_overrun_once", 64'(ov_cnt - ov0), 64'd1);
    chk("bp_alpha_kept", 64'(alpha), 64'hC0490FDB);
    chk("bp_bravo_kept", 64'(bravo), 64'h3F800000);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_valid_fall", 64'(out_valid), 64'd0);
    wait_drain("bp_drain");

    // Frame error on byte 2, then a clean pair.
    fe0 = fe_cnt;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b0);
    idle(20);
    chk("fe_pulse_once", 64'(fe_cnt - fe0), 64'd1);
    exp_q.push_back({32'h0000803F, 32'h00000040});
    send_pair(32'h0000803F, 32'h00000040);
    wait_drain("fe_recover_drain");

    // Short low glitch must not start a byte.
    fe0 = fe_cnt;
    rx_serial = 1'b0;
    repeat (CPB / 4) @(posedge clk);
    #1;
    idle(3 * CPB);
    chk("glitch_no_pair", 64'(out_valid), 64'd0);
    exp_q.push_back({32'h41200000, 32'hC1200000});
    send_pair(32'h41200000, 32'hC1200000);
    wait_drain("glitch_drain");
    chk("glitch_no_fe", 64'(fe_cnt - fe0), 64'd0);

    // Gap timeout discards three partial bytes.
    gt0 = gt_cnt;
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    send_byte(8'hCC, 1'b1);
    idle(GAP * CPB + 4 * CPB);
    chk("gap_pulse_once", 64'(gt_cnt - gt0), 64'd1);
    exp_q.push_back({32'h7F800000, 32'hFF800000});
    send_pair(32'h7F800000, 32'hFF800000);
    wait_drain("gap_drain");

    // Reset mid-pair with a pair held.
    out_ready = 1'b0;
    send_pair(32'h12345678, 32'h9ABCDEF0);
    chk("rst_pre_valid", 64'(out_valid), 64'd1);
    for (int i = 0; i < 5; i++) send_byte(8'hE0 + 8'(i), 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_mid_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_data", {alpha, bravo}, 64'd0);
    out_ready = 1'b1;
    exp_q.push_back({32'h3F800000, 32'h40400000});
    send_pair(32'h3F800000, 32'h40400000);
    wait_drain("rst_fresh_drain");
    idle(4);
    chk("total_pulses", {fe_cnt[15:0], ov_cnt[15:0], gt_cnt[15:0], 16'd0},
        {16'd1, 16'd1, 16'd1, 16'd0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
